// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
//
// Decode-stage register file with a scoreboard of in-flight results.
// Two read ports return their data one cycle after the address is presented.
// Each register has a pending bit. Decode uses that bit to stall on operands
// whose producer has not yet written back.
//
// Parameters
//   DATA_W   register width in bits
//   ADDR_W   register address width; NREGS = 2**ADDR_W
//   ZERO_REG 1 = register 0 always reads as zero and is never written or marked
//   BYPASS   1 = a write and a read on the same edge return the new data
//            0 = that read returns the value held before the write
//
// Ports
//   clock           rising-edge clock
//   reset           synchronous active-high reset, has priority over all else
//   read_en         sample both read ports on this edge
//   read_reg1/2     read addresses
//   reg_write       write enable; also retires the pending bit of write_reg
//   write_reg       write address
//   write_reg_data  write data
//   mark_en         a producer for mark_reg has issued; set its pending bit
//   mark_reg        destination register of that producer
//   read_data1/2    registered read data
//   busy1/2         registered pending flags for the sampled addresses
//   read_valid      high for the one cycle after a read_en edge
//   pending         full scoreboard vector, bit r = register r pending
// -----------------------------------------------------------------------------
module regfile_sb #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    read_en,
    input  logic [ADDR_W-1:0]       read_reg1,
    input  logic [ADDR_W-1:0]       read_reg2,
    input  logic                    reg_write,
    input  logic [ADDR_W-1:0]       write_reg,
    input  logic [DATA_W-1:0]       write_reg_data,
    input  logic                    mark_en,
    input  logic [ADDR_W-1:0]       mark_reg,
    output logic [DATA_W-1:0]       read_data1,
    output logic [DATA_W-1:0]       read_data2,
    output logic                    busy1,
    output logic                    busy2,
    output logic                    read_valid,
    output logic [(1<<ADDR_W)-1:0]  pending
);

    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_reg [NREGS];
    logic [NREGS-1:0]  pending_reg;
    logic [NREGS-1:0]  pending_next;
    logic              read_valid_reg;
    logic              write_ok;

    // A write to the hardwired zero register is dropped. Register 0 therefore
    // keeps its reset value of zero.
    assign write_ok = reg_write && !((ZERO_REG != 0) && (write_reg == '0));

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_reg[r] <= '0;
            end
        end else if (write_ok) begin
            regs_reg[write_reg] <= write_reg_data;
        end
    end

    // Scoreboard next state. A mark outranks a write-back to the same register.
    // The write-back belongs to an older producer, and the newly issued producer
    // has not yet produced its result.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_pend
            if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
                assign pending_next[gi] = 1'b0;
            end else begin : g_live
                logic mark_hit;
                logic write_hit;
                assign mark_hit  = mark_en   && (mark_reg  == ADDR_W'(gi));
                assign write_hit = reg_write && (write_reg == ADDR_W'(gi));
                assign pending_next[gi] = mark_hit ? 1'b1 :
                                          write_hit ? 1'b0 : pending_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    // Read ports. The ports are identical; the only difference is which
    // address each one selects.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic [ADDR_W-1:0] addr;
            logic              zero_addr;
            logic              bypass_hit;
            logic [DATA_W-1:0] data_next;
            logic [DATA_W-1:0] data_reg;
            logic              busy_next;
            logic              busy_reg;

            assign addr       = (gi == 0) ? read_reg1 : read_reg2;
            assign zero_addr  = (ZERO_REG != 0) && (addr == '0);
            assign bypass_hit = (BYPASS != 0) && reg_write && (write_reg == addr);

            // With bypass, the reader sees the state as it stands after this
            // edge: the new data and the updated pending bit. Without bypass,
            // the reader sees the state as it stood before this edge.
            always_comb begin
                data_next = regs_reg[addr];
                busy_next = (BYPASS != 0) ? pending_next[addr] : pending_reg[addr];
                if (bypass_hit) begin
                    data_next = write_reg_data;
                end
                if (zero_addr) begin
                    data_next = '0;
                    busy_next = 1'b0;
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    data_reg <= '0;
                    busy_reg <= 1'b0;
                end else if (read_en) begin
                    data_reg <= data_next;
                    busy_reg <= busy_next;
                end
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            read_valid_reg <= 1'b0;
        end else begin
            read_valid_reg <= read_en;
        end
    end

    assign read_data1 = g_port[0].data_reg;
    assign read_data2 = g_port[1].data_reg;
    assign busy1      = g_port[0].busy_reg;
    assign busy2      = g_port[1].busy_reg;
    assign read_valid = read_valid_reg;
    assign pending    = pending_reg;

endmodule

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb
//
// Two instances share one stimulus stream:
//   dut_a : DATA_W=8,  ADDR_W=5, ZERO_REG=1, BYPASS=1
//   dut_b : DATA_W=32, ADDR_W=4, ZERO_REG=0, BYPASS=0
// dut_b sees only the low four address bits of every address.
//
// A behavioural model of each configuration predicts the outputs. A compare
// process checks both instances on every falling edge. Directed steps also
// check hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_regfile_sb;

    logic        clock = 1'b0;
    logic        reset;
    logic        read_en;
    logic [4:0]  ra1, ra2, wa, ma;
    logic        reg_write, mark_en;
    logic [31:0] wd;

    logic [7:0]  a_rd1, a_rd2;
    logic        a_b1, a_b2, a_valid;
    logic [31:0] a_pend;
    logic [31:0] b_rd1, b_rd2;
    logic        b_b1, b_b2, b_valid;
    logic [15:0] b_pend;

    always #5 clock = ~clock;

    regfile_sb #(.DATA_W(8), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clock(clock), .reset(reset), .read_en(read_en),
        .read_reg1(ra1), .read_reg2(ra2),
        .reg_write(reg_write), .write_reg(wa), .write_reg_data(wd[7:0]),
        .mark_en(mark_en), .mark_reg(ma),
        .read_data1(a_rd1), .read_data2(a_rd2), .busy1(a_b1), .busy2(a_b2),
        .read_valid(a_valid), .pending(a_pend)
    );

    regfile_sb #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clock(clock), .reset(reset), .read_en(read_en),
        .read_reg1(ra1[3:0]), .read_reg2(ra2[3:0]),
        .reg_write(reg_write), .write_reg(wa[3:0]), .write_reg_data(wd),
        .mark_en(mark_en), .mark_reg(ma[3:0]),
        .read_data1(b_rd1), .read_data2(b_rd2), .busy1(b_b1), .busy2(b_b2),
        .read_valid(b_valid), .pending(b_pend)
    );

    // ---------------- behavioural model --------------------------------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        checking = 1'b0;

    logic [31:0] m_regs [2][32];
    logic [31:0] m_pend [2];
    logic [31:0] e_rd1 [2];
    logic [31:0] e_rd2 [2];
    logic        e_b1 [2];
    logic        e_b2 [2];
    logic        e_valid [2];

    function automatic int amask(int c);
        return (c == 0) ? 31 : 15;
    endfunction

    function automatic logic [31:0] dmask(int c);
        return (c == 0) ? 32'h0000_00FF : 32'hFFFF_FFFF;
    endfunction

    function automatic logic has_zero(int c);
        return c == 0;
    endfunction

    function automatic logic has_bypass(int c);
        return c == 0;
    endfunction

    // Scoreboard as it stands after the current edge: retire, then mark
    // (so the newer producer wins), then force register 0 clear if hardwired.
    function automatic logic [31:0] pend_after(int c);
        logic [31:0] p;
        p = m_pend[c];
        if (reg_write) p[int'(wa) & amask(c)] = 1'b0;
        if (mark_en)   p[int'(ma) & amask(c)] = 1'b1;
        if (has_zero(c)) p[0] = 1'b0;
        return p;
    endfunction

    function automatic logic [31:0] read_val(int c, logic [4:0] a);
        int idx;
        idx = int'(a) & amask(c);
        if (has_zero(c) && idx == 0) return 32'h0;
        if (has_bypass(c) && reg_write && ((int'(wa) & amask(c)) == idx))
            return wd & dmask(c);
        return m_regs[c][idx];
    endfunction

    function automatic logic read_busy(int c, logic [4:0] a);
        int idx;
        logic [31:0] p;
        idx = int'(a) & amask(c);
        if (has_zero(c) && idx == 0) return 1'b0;
        p = has_bypass(c) ? pend_after(c) : m_pend[c];
        return p[idx];
    endfunction

    always @(posedge clock) begin
        for (int c = 0; c < 2; c++) begin
            if (reset) begin
                for (int r = 0; r < 32; r++) m_regs[c][r] <= 32'h0;
                m_pend[c]  <= 32'h0;
                e_rd1[c]   <= 32'h0;
                e_rd2[c]   <= 32'h0;
                e_b1[c]    <= 1'b0;
                e_b2[c]    <= 1'b0;
                e_valid[c] <= 1'b0;
            end else begin
                if (reg_write && !(has_zero(c) && ((int'(wa) & amask(c)) == 0)))
                    m_regs[c][int'(wa) & amask(c)] <= wd & dmask(c);
                m_pend[c] <= pend_after(c);
                if (read_en) begin
                    e_rd1[c] <= read_val(c, ra1);
                    e_rd2[c] <= read_val(c, ra2);
                    e_b1[c]  <= read_busy(c, ra1);
                    e_b2[c]  <= read_busy(c, ra2);
                end
                e_valid[c] <= read_en;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of both instances against the model.
    always @(negedge clock) begin
        if (checking) begin
            chk("A.read_data1", 32'(a_rd1), e_rd1[0]);
            chk("A.read_data2", 32'(a_rd2), e_rd2[0]);
            chk("A.busy1",      32'(a_b1), 32'(e_b1[0]));
            chk("A.busy2",      32'(a_b2), 32'(e_b2[0]));
            chk("A.read_valid", 32'(a_valid), 32'(e_valid[0]));
            chk("A.pending",    a_pend, m_pend[0]);
            chk("B.read_data1", b_rd1, e_rd1[1]);
            chk("B.read_data2", b_rd2, e_rd2[1]);
            chk("B.busy1",      32'(b_b1), 32'(e_b1[1]));
            chk("B.busy2",      32'(b_b2), 32'(e_b2[1]));
            chk("B.read_valid", 32'(b_valid), 32'(e_valid[1]));
            chk("B.pending",    32'(b_pend), m_pend[1]);
        end
    end

    // ---------------- directed stimulus ---------------------------------------
    task automatic idle();
        reset = 1'b0; read_en = 1'b0; reg_write = 1'b0; mark_en = 1'b0;
        ra1 = '0; ra2 = '0; wa = '0; ma = '0; wd = '0;
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic do_read(input logic [4:0] r1, input logic [4:0] r2);
        read_en = 1'b1; ra1 = r1; ra2 = r2;
    endtask

    task automatic do_write(input logic [4:0] r, input logic [31:0] d);
        reg_write = 1'b1; wa = r; wd = d;
    endtask

    task automatic do_mark(input logic [4:0] r);
        mark_en = 1'b1; ma = r;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        checking = 1'b1;
        chk("reset A.read_valid", 32'(a_valid), 32'h0);
        chk("reset A.pending", a_pend, 32'h0);
        idle(); tick();

        // Reset mid-operation
        do_write(5'd3, 32'h5A); tick(); idle();
        do_mark(5'd7); do_read(5'd3, 5'd7); tick();
        chk("mid A.read_data1 r3", 32'(a_rd1), 32'h5A);
        chk("mid A.busy2 r7", 32'(a_b2), 32'h1);
        chk("mid A.pending[7]", 32'(a_pend[7]), 32'h1);
        idle();
        reset = 1'b1; do_write(5'd4, 32'h11); tick(); idle();
        chk("rst A.read_data1", 32'(a_rd1), 32'h0);
        chk("rst A.busy2", 32'(a_b2), 32'h0);
        chk("rst A.pending", a_pend, 32'h0);
        chk("rst B.pending", 32'(b_pend), 32'h0);
        chk("rst B.read_data1", b_rd1, 32'h0);
        do_read(5'd3, 5'd4); tick(); idle();
        chk("post-rst A r3", 32'(a_rd1), 32'h0);
        chk("post-rst A r4", 32'(a_rd2), 32'h0);
        chk("post-rst B r3", b_rd1, 32'h0);
        chk("post-rst B r4", b_rd2, 32'h0);

        // Basic write then read
        do_write(5'd31, 32'hFF); tick(); idle();
        do_read(5'd31, 5'd0); tick(); idle();
        chk("basic A r31", 32'(a_rd1), 32'hFF);
        chk("basic A r0", 32'(a_rd2), 32'h0);
        chk("basic A valid", 32'(a_valid), 32'h1);
        chk("basic B r15", b_rd1, 32'hFF);
        tick();
        chk("basic A valid drop", 32'(a_valid), 32'h0);
        chk("basic A hold", 32'(a_rd1), 32'hFF);

        // Same-edge write and read: bypass on A, old value on B
        do_write(5'd5, 32'hA5); do_read(5'd5, 5'd5); tick(); idle();
        chk("bypass A r5", 32'(a_rd1), 32'hA5);
        chk("nobypass B r5", b_rd1, 32'h0);
        do_read(5'd5, 5'd5); tick(); idle();
        chk("nobypass B r5 later", b_rd1, 32'hA5);

        // Zero register
        do_write(5'd0, 32'h77); do_mark(5'd0); tick(); idle();
        do_read(5'd0, 5'd0); tick(); idle();
        chk("zero A data", 32'(a_rd1), 32'h0);
        chk("zero A busy1", 32'(a_b1), 32'h0);
        chk("zero A pending[0]", 32'(a_pend[0]), 32'h0);
        chk("nozero B data", b_rd1, 32'h77);
        chk("nozero B pending[0]", 32'(b_pend[0]), 32'h1);

        // Scoreboard
        do_mark(5'd9); tick(); idle();
        do_read(5'd9, 5'd9); tick(); idle();
        chk("sb A busy1 r9", 32'(a_b1), 32'h1);
        chk("sb B busy1 r9", 32'(b_b1), 32'h1);
        do_write(5'd9, 32'h3C); do_read(5'd9, 5'd9); tick(); idle();
        chk("sb A busy1 retire", 32'(a_b1), 32'h0);
        chk("sb A data 3C", 32'(a_rd1), 32'h3C);
        chk("sb B busy1 old", 32'(b_b1), 32'h1);
        chk("sb B pending[9] clr", 32'(b_pend[9]), 32'h0);
        do_write(5'd9, 32'h3C); do_mark(5'd9); tick(); idle();
        chk("sb A mark+write", 32'(a_pend[9]), 32'h1);
        chk("sb B mark+write", 32'(b_pend[9]), 32'h1);

        // Sweep of the 32-bit, 16-entry instance
        for (int r = 1; r < 16; r++) begin
            do_write(5'(r), 32'hDEAD_0000 + 32'(r)); tick(); idle();
        end
        for (int r = 1; r < 16; r += 2) begin
            if (r == 15) do_read(5'd15, 5'd15);
            else         do_read(5'(r), 5'(r + 1));
            tick(); idle();
            chk("sweep B rd1", b_rd1, 32'hDEAD_0000 + 32'(r));
            chk("sweep B rd2", b_rd2, 32'hDEAD_0000 + 32'((r == 15) ? 15 : r + 1));
            tick();
            chk("sweep B hold", b_rd1, 32'hDEAD_0000 + 32'(r));
            chk("sweep B valid low", 32'(b_valid), 32'h0);
        end

        // Deterministic mixed traffic, compared cycle by cycle against the model
        for (int i = 0; i < 200; i++) begin
            reset     = (i == 150);
            read_en   = (i % 3) != 0;
            ra1       = 5'((i * 7) % 32);
            ra2       = 5'((i * 13) % 32);
            reg_write = (i % 2) == 1;
            wa        = 5'((i * 5) % 32);
            wd        = (32'(i) * 32'h0101_0101) ^ 32'h5A5A_A5A5;
            mark_en   = (i % 4) == 1 || (i % 7) == 3;
            ma        = 5'((i * 11) % 32);
            tick();
        end
        idle(); tick();

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
